arb4_rr_stream: RTL and testbench
=================================

# arb4_rr_stream

Round-robin arbiter and sequencer that shares one DATA_W-wide 4-to-1 multiplexed output path between four requesters. Registers a one-hot grant and 2-bit mux select, presents the selected requester's data on a valid/ready stream, and optionally holds the grant for bursts. Sits in front of the shared 4-to-1 mux datapath and any single-ported consumer downstream.

## Interface
- DATA_W, 32, width of each data input and of out_data
- MAX_BURST, 4, max beats per grant when bursting is compiled in (1..16)
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- req  in  4  request per requester, level, held until acked or abandoned
- data0..data3  in  DATA_W each  requester payload, stable while req high
- grant  out  4  registered one-hot grant (0 = none)
- sel  out  2  registered mux select, encodes grant (held at last value when grant = 0)
- ack  out  4  one-hot beat acknowledge: grant & {4{out_valid & out_ready}}
- out_valid  out  1  stream valid
- out_data  out  DATA_W  selected data; 0 when out_valid = 0
- out_ready  in  1  downstream ready

## Operation
- States: IDLE (grant = 0), GNT (grant = one-hot of sel).
- Pointer ptr[1:0] = last-served requester. Winner = first req bit set scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
- IDLE: any req -> register winner into grant/sel, beat count cnt <= 0, go GNT. No req -> stay.
- GNT: out_valid = req[sel]; out_data = data[sel] when valid.
- Beat = out_valid & out_ready; ack[sel] pulses that cycle.
- Release occurs in GNT when: (a) beat and burst ends, or (b) req[sel] = 0 (abandon, no transfer).
- Burst ends when bursting compiled out, or cnt = MAX_BURST-1, or req[sel] is low next… specifically: on a beat, stay if bursting enabled and cnt < MAX_BURST-1 (cnt <= cnt+1); else release. A requester ending its burst early drops req, which triggers (b).
- On release: ptr <= sel; arbitrate immediately with the updated ptr over current req masked by ~grant; winner -> GNT next cycle (no bubble); none -> IDLE.
- Current holder can win again only via a later IDLE arbitration (no other requests pending).
- cnt width 4 bits; never wraps (bounded by MAX_BURST-1).

## Timing
- Reset (reset_n low at edge): grant = 0, sel = 0, ptr = 3 (requester 0 first), cnt = 0, state IDLE; out_valid = 0, out_data = 0, ack = 0. Reset mid-burst aborts with no ack.
- Grant latency: req rising in cycle N while IDLE -> grant/out_valid in N+1.
- Handover: release beat in cycle N -> next grant in N+1; out_valid may stay high back-to-back.
- out_valid, out_data, ack combinational from registered sel and inputs; no comb path from out_ready to out_valid.
- out_ready low: grant and data held; cnt unchanged.
- Simultaneous requests: resolved strictly by pointer order; max wait for any continuous requester = 3 grants.

## Configuration
- ARB4_BURST_EN defined: grant held up to MAX_BURST beats while req stays high and out_ready accepts.
- Undefined: every grant is exactly one beat (MAX_BURST ignored, cnt logic removed); rearbitrate after each beat.

## Test plan
- Reset: hold reset_n low 2 cycles with req = 4'b1111 -> grant = 0, out_valid = 0, out_data = 0; release -> cycle +1 grant = 4'b0001.
- Single-beat RR (burst off): req = 4'b1111, out_ready = 1 constant -> grant sequence 0001, 0010, 0100, 1000, 0001, one ack per cycle, no bubbles.
- Burst (ARB4_BURST_EN, MAX_BURST = 4): req = 4'b0101, out_ready = 1 -> requester 0 gets 4 acks, then requester 2 gets 4, alternating.
- Backpressure: granted req 1, data1 = 32'hDEADBEEF, out_ready low 5 cycles -> out_valid = 1, out_data stable, ack = 0; ready high -> ack = 4'b0010 single cycle.
- Abandon: req[3] granted then dropped before out_ready -> no ack, next cycle grant moves to pending req[0], ptr = 3.
- Mid-burst reset: reset_n low during beat 2 of a burst -> next cycle all outputs at reset values, first post-reset grant to requester 0.

Source files
------------

// File: rtl/arb4_rr_stream_if.sv
// Bundle shared between the four-requester round-robin arbiter and its environment.
// The slave side is the arbiter; the master side drives requests and the downstream ready.
interface arb4_rr_stream_if #(
  parameter int DATA_W = 32
);
  logic [3:0]        req;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] data3;
  logic [3:0]        grant;
  logic [1:0]        sel;
  logic [3:0]        ack;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output req, data0, data1, data2, data3, out_ready,
    input  grant, sel, ack, out_valid, out_data
  );

  modport slave (
    input  req, data0, data1, data2, data3, out_ready,
    output grant, sel, ack, out_valid, out_data
  );
endinterface

// File: rtl/arb4_rr_stream.sv
// Round-robin arbiter sharing one 4-to-1 muxed valid/ready stream between four requesters.
// Optional burst hold (up to MAX_BURST beats per grant) is compiled in with ARB4_BURST_EN.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no grant; arbitrate over req from ptr each cycle
//   S_GNT  | grant = one-hot(sel); stream presents data[sel] while req[sel]
module arb4_rr_stream #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              reset_n,
  arb4_rr_stream_if.slave  bus
);

  typedef enum logic {
    S_IDLE,
    S_GNT
  } state_t;

  if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_max_burst
    $error("arb4_rr_stream: MAX_BURST must be in 1..16");
  end

  state_t            state, state_nxt;
  logic [3:0]        grant, grant_nxt;
  logic [1:0]        sel, sel_nxt;
  logic [1:0]        ptr, ptr_nxt;
  logic              valid;
  logic              beat;
  logic              burst_end;
  logic              release_gnt;
  logic [DATA_W-1:0] data_mux;
  logic [1:0]        arb_base;
  logic [3:0]        arb_req;
  logic [2:0]        arb_res;
  logic              arb_found;
  logic [1:0]        arb_idx;

  // Returns {found, index}; scanning from base+4 down to base+1 lets base+1 win.
  function automatic logic [2:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k + 1);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    data_mux = '0;
    unique case (sel)
      2'd0: data_mux = bus.data0;
      2'd1: data_mux = bus.data1;
      2'd2: data_mux = bus.data2;
      2'd3: data_mux = bus.data3;
    endcase
  end

  assign valid = (state == S_GNT) && bus.req[sel];
  assign beat  = valid && bus.out_ready;

  assign bus.grant     = grant;
  assign bus.sel       = sel;
  assign bus.out_valid = valid;
  assign bus.out_data  = valid ? data_mux : '0;
  assign bus.ack       = grant & {4{beat}};

  // On release the holder is masked out so it cannot immediately win again.
  assign arb_base  = (state == S_IDLE) ? ptr : sel;
  assign arb_req   = (state == S_IDLE) ? bus.req : (bus.req & ~grant);
  assign arb_res   = rr_pick(arb_base, arb_req);
  assign arb_found = arb_res[2];
  assign arb_idx   = arb_res[1:0];

`ifdef ARB4_BURST_EN
  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);
  logic [3:0] cnt, cnt_nxt;
  assign burst_end = (cnt == LAST_BEAT);
`else
  assign burst_end = 1'b1;
`endif

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    sel_nxt     = sel;
    ptr_nxt     = ptr;
    release_gnt = 1'b0;
`ifdef ARB4_BURST_EN
    cnt_nxt     = cnt;
`endif
    unique case (state)
      S_IDLE: begin
        if (arb_found) begin
          state_nxt = S_GNT;
          grant_nxt = 4'b0001 << arb_idx;
          sel_nxt   = arb_idx;
`ifdef ARB4_BURST_EN
          cnt_nxt   = '0;
`endif
        end
      end
      S_GNT: begin
        release_gnt = !bus.req[sel] || (beat && burst_end);
        if (release_gnt) begin
          ptr_nxt = sel;
          if (arb_found) begin
            grant_nxt = 4'b0001 << arb_idx;
            sel_nxt   = arb_idx;
`ifdef ARB4_BURST_EN
            cnt_nxt   = '0;
`endif
          end else begin
            state_nxt = S_IDLE;
            grant_nxt = '0;
          end
`ifdef ARB4_BURST_EN
        end else if (beat) begin
          cnt_nxt = cnt + 4'd1;
`endif
        end
      end
    endcase
  end

  // ptr resets to 3 so requester 0 is first in line after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      grant <= '0;
      sel   <= '0;
      ptr   <= 2'd3;
`ifdef ARB4_BURST_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
`ifdef ARB4_BURST_EN
      cnt   <= cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_arb4_rr_stream.sv
// Self-checking bench for arb4_rr_stream: directed scenarios plus randomized traffic,
// all compared against a requester-level round-robin model kept in the bench.
module tb_arb4_rr_stream;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
`ifdef ARB4_BURST_EN
  localparam int BURST_LEN = MAX_BURST;
`else
  localparam int BURST_LEN = 1;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [3:0]        req;
  logic              out_ready;
  logic [DATA_W-1:0] data [4];
  int                tests = 0;
  int                fails = 0;

  // Model state: who holds the grant (-1 = nobody), who was served last, beats done.
  int         m_holder;
  int         m_last;
  int         m_beats;
  logic [1:0] m_sel;

  arb4_rr_stream_if #(.DATA_W(DATA_W)) bus ();

  arb4_rr_stream #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.req       = req;
  assign bus.out_ready = out_ready;
  assign bus.data0     = data[0];
  assign bus.data1     = data[1];
  assign bus.data2     = data[2];
  assign bus.data3     = data[3];

  always #5 clk = ~clk;

  function automatic int pick(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_holder = -1;
    m_last   = 3;
    m_beats  = 0;
    m_sel    = 2'd0;
  endfunction

  function automatic logic [42:0] model_out();
    logic [3:0]        g;
    logic [3:0]        a;
    logic              v;
    logic [DATA_W-1:0] d;
    g = '0; a = '0; v = 1'b0; d = '0;
    if (m_holder >= 0) begin
      g[m_holder] = 1'b1;
      v = req[m_holder];
      if (v) d = data[m_holder];
      if (v && out_ready) a[m_holder] = 1'b1;
    end
    return {g, m_sel, a, v, d};
  endfunction

  // Advance the model across one rising edge using the inputs currently applied.
  function automatic void model_edge();
    logic [3:0] r;
    logic       beat;
    if (!reset_n) begin
      model_reset();
    end else if (m_holder < 0) begin
      m_holder = pick(m_last, req);
      m_beats  = 0;
      if (m_holder >= 0) m_sel = 2'(m_holder);
    end else begin
      beat = req[m_holder] && out_ready;
      if (!req[m_holder] || (beat && (m_beats + 1 >= BURST_LEN))) begin
        m_last = m_holder;
        r = req;
        r[m_holder] = 1'b0;
        m_holder = pick(m_last, r);
        m_beats  = 0;
        if (m_holder >= 0) m_sel = 2'(m_holder);
      end else if (beat) begin
        m_beats++;
      end
    end
  endfunction

  function automatic void rand_data();
    for (int i = 0; i < 4; i++) data[i] = $urandom;
  endfunction

  task automatic test_reset();
    logic [42:0] got, want;
    reset_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) reset_n = 1'b1;
      @(negedge clk);
      got = {bus.grant, bus.sel, bus.ack, bus.out_valid, bus.out_data};
      want = model_out();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL reset_model c%0d got=%h want=%h", c, got, want);
      end
      tests++;
      if (bus.grant !== 4'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.ack !== 4'b0) begin
        fails++;
        $display("FAIL reset_values c%0d grant=%b valid=%b data=%h ack=%b want all zero",
                 c, bus.grant, bus.out_valid, bus.out_data, bus.ack);
      end
      model_edge();
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests++;
    if (bus.grant !== 4'b0001) begin
      fails++;
      $display("FAIL reset_first_grant got=%b want=0001", bus.grant);
    end
    model_edge();
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [42:0] got, want;
    req = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      rand_data();
      @(negedge clk);
      got = {bus.grant, bus.sel, bus.ack, bus.out_valid, bus.out_data};
      want = model_out();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL rr_model c%0d got=%h want=%h", c, got, want);
      end
      tests++;
      if (bus.out_valid !== 1'b1 || !$onehot(bus.ack)) begin
        fails++;
        $display("FAIL rr_no_bubble c%0d valid=%b ack=%b want valid=1 one-hot ack",
                 c, bus.out_valid, bus.ack);
      end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_burst();
    logic [42:0] got, want;
    int n0, n2, nodd;
    n0 = 0; n2 = 0; nodd = 0;
    req = 4'b0101; out_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      rand_data();
      @(negedge clk);
      got = {bus.grant, bus.sel, bus.ack, bus.out_valid, bus.out_data};
      want = model_out();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL burst_model c%0d got=%h want=%h", c, got, want);
      end
      if (bus.ack[0] === 1'b1) n0++;
      if (bus.ack[2] === 1'b1) n2++;
      if (bus.ack[1] !== 1'b0 || bus.ack[3] !== 1'b0) nodd++;
      model_edge();
      @(posedge clk); #1;
    end
    tests++;
    if (nodd != 0 || n0 - n2 > BURST_LEN || n2 - n0 > BURST_LEN || n0 + n2 < 20) begin
      fails++;
      $display("FAIL burst_share acks0=%0d acks2=%0d stray=%0d want balanced within %0d, none stray",
               n0, n2, nodd, BURST_LEN);
    end
  endtask

  task automatic test_backpressure();
    logic [42:0] got, want;
    req = 4'b0000; out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) begin
        req = 4'b0010;
        data[1] = 32'hDEADBEEF;
      end
      if (c == 8) out_ready = 1'b1;
      if (c == 9) out_ready = 1'b0;
      @(negedge clk);
      got = {bus.grant, bus.sel, bus.ack, bus.out_valid, bus.out_data};
      want = model_out();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL bp_model c%0d got=%h want=%h", c, got, want);
      end
      if (c >= 3 && c <= 7) begin
        tests++;
        if (bus.grant !== 4'b0010 || bus.out_valid !== 1'b1 ||
            bus.out_data !== 32'hDEADBEEF || bus.ack !== 4'b0) begin
          fails++;
          $display("FAIL bp_hold c%0d grant=%b valid=%b data=%h ack=%b want 0010/1/deadbeef/0000",
                   c, bus.grant, bus.out_valid, bus.out_data, bus.ack);
        end
      end
      if (c == 8 || c == 9) begin
        tests++;
        if (bus.ack !== ((c == 8) ? 4'b0010 : 4'b0000)) begin
          fails++;
          $display("FAIL bp_ack c%0d got=%b want=%b", c, bus.ack, (c == 8) ? 4'b0010 : 4'b0000);
        end
      end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abandon();
    logic [42:0] got, want;
    req = 4'b0000; out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) req = 4'b1000;
      if (c == 3) req = 4'b1001;
      if (c == 4) req = 4'b0001;
      @(negedge clk);
      got = {bus.grant, bus.sel, bus.ack, bus.out_valid, bus.out_data};
      want = model_out();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL abandon_model c%0d got=%h want=%h", c, got, want);
      end
      if (c == 4) begin
        tests++;
        if (bus.grant !== 4'b1000 || bus.out_valid !== 1'b0 || bus.ack !== 4'b0) begin
          fails++;
          $display("FAIL abandon_drop grant=%b valid=%b ack=%b want 1000/0/0000",
                   bus.grant, bus.out_valid, bus.ack);
        end
      end
      if (c == 5) begin
        tests++;
        if (bus.grant !== 4'b0001 || bus.sel !== 2'd0) begin
          fails++;
          $display("FAIL abandon_next grant=%b sel=%0d want 0001/0", bus.grant, bus.sel);
        end
      end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_burst_reset();
    logic [42:0] got, want;
    req = 4'b0000; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) req = 4'b0101;
      if (c == 4) reset_n = 1'b0;
      if (c == 5) reset_n = 1'b1;
      rand_data();
      @(negedge clk);
      got = {bus.grant, bus.sel, bus.ack, bus.out_valid, bus.out_data};
      want = model_out();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL mbr_model c%0d got=%h want=%h", c, got, want);
      end
      if (c == 5) begin
        tests++;
        if (bus.grant !== 4'b0 || bus.sel !== 2'd0 || bus.out_valid !== 1'b0 ||
            bus.out_data !== '0 || bus.ack !== 4'b0) begin
          fails++;
          $display("FAIL mbr_reset grant=%b sel=%0d valid=%b data=%h ack=%b want all zero",
                   bus.grant, bus.sel, bus.out_valid, bus.out_data, bus.ack);
        end
      end
      if (c == 6) begin
        tests++;
        if (bus.grant !== 4'b0001) begin
          fails++;
          $display("FAIL mbr_first_grant got=%b want=0001", bus.grant);
        end
      end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [42:0] got, want;
    for (int c = 0; c < 600; c++) begin
      reset_n   = ($urandom_range(0, 59) != 0);
      req       = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      @(negedge clk);
      got = {bus.grant, bus.sel, bus.ack, bus.out_valid, bus.out_data};
      want = model_out();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL random_model c%0d req=%b rdy=%b got=%h want=%h", c, req, out_ready, got, want);
      end
      model_edge();
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
    rand_data();
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_round_robin();
    test_burst();
    test_backpressure();
    test_abandon();
    test_mid_burst_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
